// File: rtl/ltc220x_pkg.sv
// Shared constants and FSM encoding for the LTC220X decimating framer.
package ltc220x_pkg;

    localparam int ADC_W = 16;
    localparam logic [ADC_W-1:0] HEADER_WORD_DEFAULT = 16'hA5A5;

    typedef logic [1:0] frame_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_SEQ  = 2'd2;
    localparam logic [1:0] ST_PAY  = 2'd3;

endpackage

// File: rtl/ltc220x_sample_fifo.sv
// Synchronous show-ahead FIFO for averaged samples; head word is visible on rd_data while not empty.
module ltc220x_sample_fifo
    import ltc220x_pkg::*;
#(
    parameter int WIDTH      = ADC_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ltc220x_decim_framer.sv
// Boxcar-decimates the LTC220X sample stream, buffers the averages and frames them as header/sequence/payload.
// Build option: LTC220X_TWOS_COMP_EN stores averages in two's complement (MSB inverted) instead of offset-binary.
module ltc220x_decim_framer
    import ltc220x_pkg::*;
#(
    parameter int               DECIM_LOG2      = 2,
    parameter int               FRAME_LEN       = 32,
    parameter int               FIFO_DEPTH_LOG2 = 4,
    parameter logic [ADC_W-1:0] HEADER_WORD     = HEADER_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ADC_W-1:0] sample_data,
    input  logic             sample_valid,
    output logic [ADC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam int ACC_W = ADC_W + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PAY_W = $clog2(FRAME_LEN);
    localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(FRAME_LEN - 1);

    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_sum;
    logic [CNT_W-1:0]         smp_cnt;
    logic                     last_smp;
    logic                     enable_q;
    logic [ADC_W-1:0]         avg;
    logic [ADC_W-1:0]         avg_conv;
    logic                     wr_strobe;
    logic [ADC_W-1:0]         wr_word;

    logic [ADC_W-1:0]         fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     fifo_rd;
    logic                     drop;

    frame_state_t             state;
    logic [15:0]              seq_num;
    logic [PAY_W-1:0]         pay_cnt;

    assign acc_sum  = acc + ACC_W'(sample_data);
    assign avg      = acc_sum[DECIM_LOG2 +: ADC_W];
    assign last_smp = (DECIM_LOG2 == 0) ? 1'b1 : (smp_cnt == CNT_W'((1 << DECIM_LOG2) - 1));

`ifdef LTC220X_TWOS_COMP_EN
    assign avg_conv = {~avg[ADC_W-1], avg[ADC_W-2:0]};
`else
    assign avg_conv = avg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            smp_cnt   <= '0;
            enable_q  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_word   <= '0;
        end else begin
            enable_q  <= enable;
            wr_strobe <= 1'b0;
            if (enable_q && !enable) begin
                acc     <= '0;
                smp_cnt <= '0;
            end else if (enable && sample_valid) begin
                if (last_smp) begin
                    // Restart from zero on the closing sample so the next window loses nothing.
                    acc       <= '0;
                    smp_cnt   <= '0;
                    wr_strobe <= 1'b1;
                    wr_word   <= avg_conv;
                end else begin
                    acc     <= acc_sum;
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end
        end
    end

    ltc220x_sample_fifo #(
        .WIDTH      (ADC_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_strobe),
        .wr_data (wr_word),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign fifo_rd = (state == ST_PAY) && !fifo_empty && out_ready;
    assign drop    = wr_strobe && fifo_full && !fifo_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            seq_num <= '0;
            pay_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enable && fifo_count != '0) state <= ST_HDR;
                ST_HDR:  if (out_ready) state <= ST_SEQ;
                ST_SEQ: begin
                    if (out_ready) begin
                        state   <= ST_PAY;
                        pay_cnt <= '0;
                    end
                end
                ST_PAY: begin
                    if (fifo_rd) begin
                        if (pay_cnt == PAY_LAST) begin
                            state   <= ST_IDLE;
                            seq_num <= seq_num + 16'd1;
                            pay_cnt <= '0;
                        end else begin
                            pay_cnt <= pay_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only flops (state, counters, FIFO storage); out_ready never reaches them combinationally.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (state)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER_WORD;
                out_sof   = 1'b1;
            end
            ST_SEQ: begin
                out_valid = 1'b1;
                out_data  = seq_num;
            end
            ST_PAY: begin
                out_valid = !fifo_empty;
                out_data  = fifo_head;
                out_eof   = !fifo_empty && (pay_cnt == PAY_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ltc220x_decim_framer.sv
// Directed bench: dut0 decimates by 4 with 4-word frames, dut1 passes samples through with 16-word frames.
`timescale 1ns/1ps
module tb_ltc220x_decim_framer;

`ifdef LTC220X_TWOS_COMP_EN
    localparam logic [15:0] MSB_FLIP = 16'h8000;
`else
    localparam logic [15:0] MSB_FLIP = 16'h0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        en0 = 1'b0, sv0 = 1'b0, rdy0 = 1'b0;
    logic [15:0] sd0 = '0;
    logic [15:0] od0, dc0;
    logic        ov0, sof0, eof0, ovf0;
    logic        en1 = 1'b0, sv1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] sd1 = '0;
    logic [15:0] od1, dc1;
    logic        ov1, sof1, eof1, ovf1;

    int total = 0;
    int bad = 0;
    int stall_bad = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic        p_stall0 = 1'b0;
    logic [17:0] p_word0 = '0;

    ltc220x_decim_framer #(.DECIM_LOG2(2), .FRAME_LEN(4), .FIFO_DEPTH_LOG2(4)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .sample_data(sd0), .sample_valid(sv0),
        .out_data(od0), .out_valid(ov0), .out_ready(rdy0), .out_sof(sof0), .out_eof(eof0),
        .overflow(ovf0), .drop_count(dc0));

    ltc220x_decim_framer #(.DECIM_LOG2(0), .FRAME_LEN(16), .FIFO_DEPTH_LOG2(4)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .sample_data(sd1), .sample_valid(sv1),
        .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .out_sof(sof1), .out_eof(eof1),
        .overflow(ovf1), .drop_count(dc1));

    // Handshake capture and stall-stability watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && ov0 && rdy0) q0.push_back({sof0, eof0, od0});
        if (!reset && ov1 && rdy1) q1.push_back({sof1, eof1, od1});
        if (!reset && p_stall0 && (!ov0 || {sof0, eof0, od0} != p_word0)) stall_bad++;
        p_stall0 = !reset && ov0 && !rdy0;
        p_word0  = {sof0, eof0, od0};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed0(input logic [15:0] v);
        sv0 = 1'b1;
        sd0 = v;
        step();
        sv0 = 1'b0;
    endtask

    task automatic feed0_avg(input logic [15:0] v);
        for (int i = 0; i < 4; i++) feed0(v);
    endtask

    task automatic feed1(input logic [15:0] v);
        sv1 = 1'b1;
        sd1 = v;
        step();
        sv1 = 1'b0;
    endtask

    function automatic logic [17:0] w(input logic sof, input logic eof, input logic [15:0] d);
        return {sof, eof, d};
    endfunction

    function automatic logic [15:0] pv(input int i);
        if (i == 0) return 16'h8000;
        if (i == 1) return 16'h0000;
        return {~i[0], 15'(i)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst0_valid got=%b exp=0", ov0); end
        total++; if ({sof0, eof0} !== 2'b00) begin bad++; $display("FAIL rst0_sof_eof got=%b exp=00", {sof0, eof0}); end
        total++; if (od0 !== 16'h0000) begin bad++; $display("FAIL rst0_data got=%h exp=0000", od0); end
        total++; if ({ovf0, dc0} !== 17'h0) begin bad++; $display("FAIL rst0_ovf_drop got=%b/%h exp=0/0000", ovf0, dc0); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst1_valid got=%b exp=0", ov1); end
        total++; if ({sof1, eof1} !== 2'b00) begin bad++; $display("FAIL rst1_sof_eof got=%b exp=00", {sof1, eof1}); end
        total++; if (od1 !== 16'h0000) begin bad++; $display("FAIL rst1_data got=%h exp=0000", od1); end
        total++; if ({ovf1, dc1} !== 17'h0) begin bad++; $display("FAIL rst1_ovf_drop got=%b/%h exp=0/0000", ovf1, dc1); end
    endtask

    task automatic test_first_frame();
        logic [17:0] exp[$];
        logic [17:0] got;
        en0 = 1'b1;
        rdy0 = 1'b1;
        q0.delete();
        for (int r = 0; r < 4; r++) begin
            feed0(16'h0010); feed0(16'h0020); feed0(16'h0030); feed0(16'h0040);
        end
        for (int c = 0; c < 50 && q0.size() < 6; c++) step();
        exp = '{w(1, 0, 16'hA5A5), w(0, 0, 16'h0000), w(0, 0, 16'h0028),
                w(0, 0, 16'h0028), w(0, 0, 16'h0028), w(0, 1, 16'h0028)};
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q0.size()) ? q0[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL first_frame w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        total++; if (q0.size() != 6) begin bad++; $display("FAIL first_frame_len got=%0d exp=6", q0.size()); end
        q0.delete();
    endtask

    task automatic test_truncation();
        logic [17:0] exp[$];
        logic [17:0] got;
        feed0(16'h0001); feed0(16'h0002); feed0(16'h0002); feed0(16'h0002);
        feed0_avg(16'hFFFF);
        feed0(16'h0000); feed0(16'h0000); feed0(16'h0000); feed0(16'h0003);
        feed0(16'h0005); feed0(16'h0005); feed0(16'h0005); feed0(16'h0006);
        for (int c = 0; c < 50 && q0.size() < 6; c++) step();
        exp = '{w(1, 0, 16'hA5A5), w(0, 0, 16'h0001), w(0, 0, 16'h0001),
                w(0, 0, 16'hFFFF), w(0, 0, 16'h0000), w(0, 1, 16'h0005)};
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q0.size()) ? q0[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL truncation w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        q0.delete();
    endtask

    task automatic test_enable_gating();
        logic [17:0] exp[$];
        logic [17:0] got;
        feed0(16'h0100);
        feed0(16'h0200);
        en0 = 1'b0;
        step();
        feed0(16'h7777); feed0(16'h7777); feed0(16'h7777);
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL disabled_idle got=%b exp=0", ov0); end
        en0 = 1'b1;
        feed0_avg(16'h0040);
        feed0_avg(16'h0080);
        feed0_avg(16'h00C0);
        feed0_avg(16'h0011);
        for (int c = 0; c < 50 && q0.size() < 6; c++) step();
        exp = '{w(1, 0, 16'hA5A5), w(0, 0, 16'h0002), w(0, 0, 16'h0040),
                w(0, 0, 16'h0080), w(0, 0, 16'h00C0), w(0, 1, 16'h0011)};
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q0.size()) ? q0[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL enable_gate w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        q0.delete();
    endtask

    task automatic test_seq_wrap();
        logic [17:0] got;
        force dut0.seq_num = 16'hFFFF;
        step();
        release dut0.seq_num;
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < 4; a++) feed0_avg(16'h1234 + 16'(f));
            for (int c = 0; c < 50 && q0.size() < 6; c++) step();
            got = (q0.size() > 1) ? q0[1] : 18'hx;
            total++;
            if (got !== w(0, 0, (f == 0) ? 16'hFFFF : 16'h0000))
                begin bad++; $display("FAIL seq_wrap f%0d got=%h exp=%h", f, got, w(0, 0, (f == 0) ? 16'hFFFF : 16'h0000)); end
            got = (q0.size() > 5) ? q0[5] : 18'hx;
            total++;
            if (got !== w(0, 1, 16'h1234 + 16'(f)))
                begin bad++; $display("FAIL seq_wrap_last f%0d got=%h exp=%h", f, got, w(0, 1, 16'h1234 + 16'(f))); end
            q0.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp[$];
        logic [17:0] got;
        logic [17:0] sum;
        logic [15:0] v;
        for (int f = 0; f < 4; f++) begin
            exp.push_back(w(1, 0, 16'hA5A5));
            exp.push_back(w(0, 0, 16'(f + 1)));
            for (int a = 0; a < 4; a++) begin
                sum = '0;
                for (int s = 0; s < 4; s++) begin
                    v = 16'((f * 16 + a * 4 + s) * 613 + 7);
                    sum = sum + {2'b00, v};
                    rdy0 = 1'($urandom_range(0, 1));
                    feed0(v);
                    rdy0 = 1'($urandom_range(0, 1));
                    step();
                end
                exp.push_back(w(0, a == 3, sum[17:2]));
            end
        end
        for (int c = 0; c < 400 && q0.size() < 24; c++) begin
            rdy0 = 1'($urandom_range(0, 1));
            step();
        end
        rdy0 = 1'b1;
        for (int c = 0; c < 20 && q0.size() < 24; c++) step();
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q0.size()) ? q0[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL b2b w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        total++; if (q0.size() != 24) begin bad++; $display("FAIL b2b_count got=%0d exp=24", q0.size()); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", stall_bad); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", ovf0); end
        q0.delete();
    endtask

    task automatic test_overflow();
        logic [17:0] got;
        en1 = 1'b1;
        rdy1 = 1'b0;
        q1.delete();
        for (int i = 0; i < 16; i++) feed1(16'h0100 + 16'(i));
        step(); step();
        total++; if ({ovf1, dc1} !== 17'h0) begin bad++; $display("FAIL fifo_full_nodrop got=%b/%h exp=0/0000", ovf1, dc1); end
        total++; if ({ov1, sof1, od1} !== {2'b11, 16'hA5A5}) begin bad++; $display("FAIL hdr_stall got=%b%b/%h exp=11/a5a5", ov1, sof1, od1); end
        feed1(16'h0110);
        step();
        total++; if ({ovf1, dc1} !== {1'b1, 16'h0001}) begin bad++; $display("FAIL first_drop got=%b/%h exp=1/0001", ovf1, dc1); end
        for (int i = 1; i < 4; i++) feed1(16'h0110 + 16'(i));
        step(); step();
        total++; if ({ovf1, dc1} !== {1'b1, 16'h0004}) begin bad++; $display("FAIL drop_count got=%b/%h exp=1/0004", ovf1, dc1); end
        rdy1 = 1'b1;
        for (int c = 0; c < 60 && q1.size() < 18; c++) step();
        for (int k = 0; k < 18; k++) begin
            got = (k < q1.size()) ? q1[k] : 18'hx;
            total++;
            if (got !== ((k == 0) ? w(1, 0, 16'hA5A5) : (k == 1) ? w(0, 0, 16'h0000) : w(0, k == 17, 16'h0100 + 16'(k - 2))))
                begin bad++; $display("FAIL ovf_drain w%0d got=%h", k, got); end
        end
        step(); step();
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL ovf_idle got=%b exp=0", ov1); end
        q1.delete();
    endtask

    task automatic test_full_rw_twos();
        logic [17:0] exp[$];
        logic [17:0] got;
        rdy1 = 1'b1;
        feed1(pv(0));
        for (int c = 0; c < 20 && q1.size() < 3; c++) step();
        rdy1 = 1'b0;
        for (int i = 1; i < 18; i++) feed1(pv(i));
        rdy1 = 1'b1;
        for (int i = 18; i < 32; i++) feed1(pv(i));
        for (int c = 0; c < 100 && q1.size() < 36; c++) step();
        for (int f = 0; f < 2; f++) begin
            exp.push_back(w(1, 0, 16'hA5A5));
            exp.push_back(w(0, 0, 16'(f + 1)));
            for (int i = 0; i < 16; i++) exp.push_back(w(0, i == 15, pv(f * 16 + i) ^ MSB_FLIP));
        end
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q1.size()) ? q1[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL full_rw w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        total++; if ({ovf1, dc1} !== {1'b1, 16'h0004}) begin bad++; $display("FAIL full_rw_nodrop got=%b/%h exp=1/0004", ovf1, dc1); end
        en1 = 1'b0;
        q1.delete();
    endtask

    task automatic test_reset_mid_pay();
        logic [17:0] exp[$];
        logic [17:0] got;
        en0 = 1'b1;
        rdy0 = 1'b0;
        feed0_avg(16'h0200);
        feed0_avg(16'h0300);
        step(); step();
        rdy0 = 1'b1;
        step(); step(); step();
        rdy0 = 1'b0;
        total++; if ({ov0, eof0, od0} !== {2'b10, 16'h0300}) begin bad++; $display("FAIL pay_before_rst got=%b%b/%h exp=10/0300", ov0, eof0, od0); end
        reset = 1'b1;
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", ov0); end
        total++; if ({ovf1, dc1} !== 17'h0) begin bad++; $display("FAIL rst_mid_ovf got=%b/%h exp=0/0000", ovf1, dc1); end
        reset = 1'b0;
        q0.delete();
        rdy0 = 1'b1;
        step();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_flushed got=%b exp=0", ov0); end
        feed0_avg(16'h0400); feed0_avg(16'h0500); feed0_avg(16'h0600); feed0_avg(16'h0700);
        for (int c = 0; c < 50 && q0.size() < 6; c++) step();
        exp = '{w(1, 0, 16'hA5A5), w(0, 0, 16'h0000), w(0, 0, 16'h0400),
                w(0, 0, 16'h0500), w(0, 0, 16'h0600), w(0, 1, 16'h0700)};
        for (int k = 0; k < exp.size(); k++) begin
            got = (k < q0.size()) ? q0[k] : 18'hx;
            total++;
            if (got !== exp[k]) begin bad++; $display("FAIL post_rst w%0d got=%h exp=%h", k, got, exp[k]); end
        end
        q0.delete();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_truncation();
        test_enable_gating();
        test_seq_wrap();
        test_back_to_back();
        test_overflow();
        test_full_rw_twos();
        test_reset_mid_pay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
